// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS frequency-sweep sequencer.
package dds_pkg;
    localparam int FW_W = 32;
    localparam int PH_W = 11;

    localparam logic MODE_SAW = 1'b0;
    localparam logic MODE_TRI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;
endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter: expire fires once every period_i+1 enabled cycles and reloads itself.
module dds_dwell_timer #(
    parameter int DW_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            enable_i,
    input  logic [DW_W-1:0] period_i,
    output logic            expire_o
);
    logic [DW_W-1:0] cnt_q;
    logic [DW_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = period_i;
        end else if (enable_i) begin
            cnt_d = (cnt_q == '0) ? period_i : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && !load_i && (cnt_q == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS frequency word K between latched endpoints,
// sawtooth or triangle, for n_sweeps periods (0 = forever). All outputs are registered.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW_W  = dds_pkg::FW_W,
    parameter int PH_W  = dds_pkg::PH_W,
    parameter int DW_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [FW_W-1:0]  f_start,
    input  logic [FW_W-1:0]  f_stop,
    input  logic [FW_W-1:0]  f_step,
    input  logic [DW_W-1:0]  dwell,
    input  logic [PH_W-1:0]  p_off,
    input  logic [CNT_W-1:0] n_sweeps,
    output logic [FW_W-1:0]  K,
    output logic [PH_W-1:0]  P,
    output logic             busy,
    output logic             sweep_tick,
    output logic             done,
    output logic             err,
    output sweep_state_t     state_o
);
    sweep_state_t     state_q, state_d;
    logic [FW_W-1:0]  k_q, k_d;
    logic [PH_W-1:0]  p_q, p_d;
    logic             busy_q, busy_d, tick_q, tick_d, done_q, done_d, err_q, err_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [FW_W-1:0]  f_start_q, f_stop_q, f_step_q;
    logic [DW_W-1:0]  dwell_q;
    logic [PH_W-1:0]  p_off_q;
    logic [CNT_W-1:0] n_q;
    logic             mode_q;
    logic             cfg_load, period_end, expire;

    // Sums carry one extra bit so an overflowing up step still saturates at f_stop.
    logic [FW_W:0]    sum_up, floor_dn;
    logic [FW_W-1:0]  up_k, dn_k;

    assign sum_up   = {1'b0, k_q} + {1'b0, f_step_q};
    assign floor_dn = {1'b0, f_start_q} + {1'b0, f_step_q};
    assign up_k     = (sum_up >= {1'b0, f_stop_q}) ? f_stop_q : sum_up[FW_W-1:0];
    assign dn_k     = ({1'b0, k_q} < floor_dn) ? f_start_q : k_q - f_step_q;

    dds_dwell_timer #(.DW_W(DW_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (cfg_load),
        .enable_i (state_q == RUN),
        .period_i (cfg_load ? dwell : dwell_q),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        p_d        = p_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;
        cfg_load   = 1'b0;
        period_end = 1'b0;
        if (abort) begin
            state_d = IDLE;
            k_d     = '0;
            p_d     = '0;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (f_step == '0 || f_start > f_stop) begin
                            err_d = 1'b1;
                        end else begin
                            cfg_load = 1'b1;
                            state_d  = RUN;
                            k_d      = f_start;
                            p_d      = p_off;
                            dir_d    = 1'b0;
                            cnt_d    = '0;
                            tick_d   = (f_start == f_stop);
                        end
                    end
                end
                RUN: begin
                    if (expire) begin
                        if (!dir_q) begin
                            if (k_q != f_stop_q) begin
                                k_d    = up_k;
                                tick_d = (up_k == f_stop_q);
                            end else if (mode_q == MODE_TRI) begin
                                dir_d  = 1'b1;
                                k_d    = dn_k;
                                tick_d = (dn_k == f_start_q);
                            end else begin
                                period_end = 1'b1;
                            end
                        end else if (k_q != f_start_q) begin
                            k_d    = dn_k;
                            tick_d = (dn_k == f_start_q);
                        end else begin
                            period_end = 1'b1;
                        end
                        if (period_end) begin
                            cnt_d = cnt_q + 1'b1;
                            if (n_q != '0 && cnt_d == n_q) begin
                                state_d = DONE;
                                k_d     = '0;
                                p_d     = '0;
                            end else if (mode_q == MODE_SAW) begin
                                k_d    = f_start_q;
                                tick_d = (f_start_q == f_stop_q);
                            end else begin
                                // Triangle turns at f_start without a second dwell there.
                                dir_d  = 1'b0;
                                k_d    = up_k;
                                tick_d = (up_k == f_stop_q);
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                    p_d     = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            p_q       <= '0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= '0;
            p_off_q   <= '0;
            n_q       <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            if (cfg_load) begin
                f_start_q <= f_start;
                f_stop_q  <= f_stop;
                f_step_q  <= f_step;
                dwell_q   <= dwell;
                p_off_q   <= p_off;
                n_q       <= n_sweeps;
                mode_q    <= mode;
            end
        end
    end

    assign K          = k_q;
    assign P          = p_q;
    assign busy       = busy_q;
    assign sweep_tick = tick_q;
    assign done       = done_q;
    assign err        = err_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed K sequences, pulses and abort/reset behaviour.
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_step = '0;
    logic [15:0] dwell = '0;
    logic [10:0] p_off = '0;
    logic [7:0]  n_sweeps = '0;
    logic [31:0] K;
    logic [10:0] P;
    logic        busy, sweep_tick, done, err;
    sweep_state_t state_o;

    int n_vec = 0;
    int n_miss = 0;

    logic [31:0] exp_q[$];
    logic        exp_tick_q[$];
    logic [10:0] exp_p;

    dds_sweep_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .p_off      (p_off),
        .n_sweeps   (n_sweeps),
        .K          (K),
        .P          (P),
        .busy       (busy),
        .sweep_tick (sweep_tick),
        .done       (done),
        .err        (err),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] k, input logic t);
        exp_q.push_back(k);
        exp_tick_q.push_back(t);
    endtask

    // Walk the expected K queue, each value held for 'hold' cycles; ends one cycle past the last.
    task automatic play(input string tag, input int hold);
        logic [31:0] k;
        logic        t;
        while (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            t = exp_tick_q.pop_front();
            for (int c = 0; c < hold; c++) begin
                check({tag, "_k"}, K, k);
                check({tag, "_tick"}, {31'b0, sweep_tick}, {31'b0, (c == 0) ? t : 1'b0});
                check({tag, "_p"}, {21'b0, P}, {21'b0, exp_p});
                check({tag, "_busy"}, {31'b0, busy}, 32'd1);
                check({tag, "_done"}, {31'b0, done}, 32'd0);
                step();
            end
        end
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_done_k"}, K, 32'd0);
        check({tag, "_done_p"}, {21'b0, P}, 32'd0);
        check({tag, "_done_busy"}, {31'b0, busy}, 32'd1);
        step();
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_idle_done"}, {31'b0, done}, 32'd0);
        check({tag, "_idle_state"}, {30'b0, state_o}, {30'b0, IDLE});
    endtask

    task automatic cfg(input logic m, input logic [31:0] fs, input logic [31:0] fe,
                       input logic [31:0] st, input logic [15:0] dw, input logic [10:0] po,
                       input logic [7:0] n);
        mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw; p_off = po; n_sweeps = n;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        // Reset
        step();
        step();
        check("rst_k", K, 32'd0);
        check("rst_p", {21'b0, P}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_flags", {29'b0, sweep_tick, done, err}, 32'd0);
        check("rst_state", {30'b0, state_o}, {30'b0, IDLE});
        rst_n = 1'b1;
        step();

        // Sawtooth, two sweeps, dwell 2
        cfg(MODE_SAW, 32'd100, 32'd130, 32'd10, 16'd2, 11'h155, 8'd2);
        exp_p = 11'h155;
        pulse_start();
        check("saw_state", {30'b0, state_o}, {30'b0, RUN});
        for (int s = 0; s < 2; s++) begin
            push(32'd100, 1'b0); push(32'd110, 1'b0); push(32'd120, 1'b0); push(32'd130, 1'b1);
        end
        play("saw", 3);
        expect_done("saw");

        // Saturation at f_stop, dwell 0
        cfg(MODE_SAW, 32'd0, 32'd25, 32'd10, 16'd0, 11'h001, 8'd1);
        exp_p = 11'h001;
        pulse_start();
        push(32'd0, 1'b0); push(32'd10, 1'b0); push(32'd20, 1'b0); push(32'd25, 1'b1);
        play("sat", 1);
        expect_done("sat");

        // Carry-out must saturate, not wrap
        cfg(MODE_SAW, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 11'h7FF, 8'd1);
        exp_p = 11'h7FF;
        pulse_start();
        push(32'hFFFF_FFF0, 1'b0); push(32'hFFFF_FFFF, 1'b1);
        play("ovf", 1);
        expect_done("ovf");

        // Triangle, one sweep
        cfg(MODE_TRI, 32'd100, 32'd130, 32'd10, 16'd0, 11'h0AA, 8'd1);
        exp_p = 11'h0AA;
        pulse_start();
        push(32'd100, 1'b0); push(32'd110, 1'b0); push(32'd120, 1'b0); push(32'd130, 1'b1);
        push(32'd120, 1'b0); push(32'd110, 1'b0); push(32'd100, 1'b1);
        play("tri", 1);
        expect_done("tri");

        // Triangle with equal endpoints: two dwells, tick on each
        cfg(MODE_TRI, 32'd77, 32'd77, 32'd5, 16'd1, 11'h003, 8'd1);
        exp_p = 11'h003;
        pulse_start();
        push(32'd77, 1'b1); push(32'd77, 1'b1);
        play("eq", 2);
        expect_done("eq");

        // Rejected starts
        cfg(MODE_SAW, 32'd10, 32'd20, 32'd0, 16'd0, 11'h0, 8'd1);
        pulse_start();
        check("rej_step_err", {31'b0, err}, 32'd1);
        check("rej_step_busy", {31'b0, busy}, 32'd0);
        step();
        check("rej_step_err_clr", {31'b0, err}, 32'd0);
        cfg(MODE_SAW, 32'd50, 32'd40, 32'd1, 16'd0, 11'h0, 8'd1);
        pulse_start();
        check("rej_order_err", {31'b0, err}, 32'd1);
        check("rej_order_busy", {31'b0, busy}, 32'd0);
        step();

        // Abort at the second step, with a simultaneous start
        cfg(MODE_SAW, 32'd100, 32'd130, 32'd10, 16'd1, 11'h123, 8'd0);
        exp_p = 11'h123;
        pulse_start();
        push(32'd100, 1'b0);
        play("abt", 2);
        check("abt_k_step2", K, 32'd110);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abt_k", K, 32'd0);
        check("abt_p", {21'b0, P}, 32'd0);
        check("abt_busy", {31'b0, busy}, 32'd0);
        check("abt_flags", {29'b0, sweep_tick, done, err}, 32'd0);
        step();
        check("abt_stay_idle", {31'b0, busy}, 32'd0);
        check("abt_no_done", {31'b0, done}, 32'd0);

        // Asynchronous reset mid-dwell
        cfg(MODE_SAW, 32'd100, 32'd130, 32'd10, 16'd3, 11'h0F0, 8'd0);
        pulse_start();
        step();
        check("arst_pre_k", K, 32'd100);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_k", K, 32'd0);
        check("arst_p", {21'b0, P}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("arst_idle", {31'b0, busy}, 32'd0);
        check("arst_tick", {31'b0, sweep_tick}, 32'd0);

        // Config changes and a second start during a sweep are ignored
        cfg(MODE_SAW, 32'd100, 32'd130, 32'd10, 16'd0, 11'h2AA, 8'd1);
        exp_p = 11'h2AA;
        pulse_start();
        f_step = 32'd3;
        p_off = 11'h007;
        f_stop = 32'd1000;
        dwell = 16'd5;
        mode = MODE_TRI;
        start = 1'b1;
        push(32'd100, 1'b0);
        play("iso_a", 1);
        start = 1'b0;
        check("iso_no_err", {31'b0, err}, 32'd0);
        push(32'd110, 1'b0); push(32'd120, 1'b0); push(32'd130, 1'b1);
        play("iso_b", 1);
        expect_done("iso");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
